sd_card_spi: RTL and testbench
==============================

// Module: sd_card_spi
// PURPOSE
//  SD-card emulator on the SPI side of the divmmc controller: consumes spi_ss/spi_clk/spi_do, drives spi_di.
//  Decodes SD SPI-mode commands, answers as an SDHC card, and moves 512-byte sectors between
//  an internal buffer and the host (MiST user_io) block interface.
// PARAMETERS
//  NCR      1          0xFF filler bytes between last command byte and R1 (1..8)
//  RD_WAIT  1          min 0xFF bytes sent after CMD17 R1 before the 0xFE token
// PORTS
//  clk_sys       in   1   system clock; spi_clk toggles at most once per clk_sys cycle
//  reset_n       in   1   asynchronous, active-low reset
//  spi_ss        in   1   chip select, active low
//  spi_clk       in   1   SPI clock, mode 0
//  spi_do        in   1   MOSI
//  spi_di        out  1   MISO
//  sd_lba        out  32  sector address (SDHC block address = command argument)
//  sd_rd         out  1   sector read request to host
//  sd_wr         out  1   sector write request to host
//  sd_ack        in   1   host busy; high while host accesses buffer
//  sd_buff_addr  in   9   host buffer byte address
//  sd_buff_dout  in   8   host->buffer write data
//  sd_buff_wr    in   1   host buffer write strobe
//  sd_buff_din   out  8   buffer->host read data, 1-cycle registered from sd_buff_addr
// BEHAVIOUR
//  Reset: spi_di=1, sd_rd=0, sd_wr=0, sd_lba=0, sd_buff_din=0, state IDLE, idle_flag=1, bitcnt=0.
//  Bit level: clk_sys samples spi_clk; rise = spi_clk & ~old_clk -> shift spi_do in, bitcnt++.
//   fall -> spi_di <= tx_byte[7-bitcnt]; tx byte loaded when bitcnt wraps 7->0.
//  spi_ss high: bitcnt=0, state=IDLE, spi_di=1; pending host handshake is not abandoned.
//  Command frame: byte with bits[7:6]=01 starts frame; 6 bytes = cmd, arg[31:0], crc (crc ignored).
//   Then NCR bytes 0xFF, then response. Non-frame bytes in IDLE ignored, MISO=0xFF.
//  Responses (R1 = {7'b0, idle_flag} unless noted):
//   CMD0 -> 0x01, sets idle_flag.  CMD8 -> R1,00,00,01,AA.  CMD55 -> R1, arms ACMD.
//   ACMD41 -> 0x00, clears idle_flag.  CMD58 -> R1,C0,FF,80,00.  CMD16 -> R1.
//   CMD17/CMD24 -> see below. Any other cmd (or ACMD other than 41) -> R1|0x04.
//   ACMD armed only for the frame directly after CMD55.
//  States: IDLE, CMD, NCR, RESP, RD_REQ, RD_TOKEN, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC,
//   WR_RESP, WR_BUSY.
//  CMD17: R1=0x00; sd_lba<=arg; sd_rd=1 held until sd_ack rises; MISO 0xFF until sd_ack falls
//   and >=RD_WAIT fillers sent; then 0xFE, 512 buffer bytes (addr 0..511), 2 CRC bytes 0xFF -> IDLE.
//  CMD24: R1=0x00; MISO 0xFF; bytes != 0xFE ignored in WR_TOKEN; after 0xFE, 512 bytes into
//   buffer 0..511, 2 CRC bytes ignored; send 0x05; sd_lba<=arg, sd_wr=1 held until sd_ack rises;
//   MISO 0x00 (busy) until sd_ack falls, then 0xFF -> IDLE.
//  Host handshake: request level, drop on sd_ack rise; completion = sd_ack fall. New request never
//   issued while previous incomplete; CMD17/24 during pending handshake waits in RD_REQ/WR_BUSY.
//  Buffer: 512x8 dual-port; SPI port has priority only logically—ports are independent; host writes
//   only while sd_ack=1. Byte index 9-bit, wraps only via state exit at 511.
//  Simultaneous sd_ack fall and spi_ss rise: handshake completes, state IDLE.
//  reset_n low mid-transfer: all state cleared asynchronously, requests drop immediately.
// TESTING
//  T1 ss low, send 40 00 00 00 00 95 + FF,FF -> 2nd FF byte returns 0x01.
//  T2 CMD8 arg 0x1AA -> 01 00 00 01 AA; CMD55+ACMD41 -> 0x00; CMD58 -> 00 C0 FF 80 00.
//  T3 CMD17 arg 0x00001234 -> R1 00, sd_rd=1, sd_lba=0x1234; host acks, fills i^0x5A;
//     after ack fall -> FE, 512 bytes i^0x5A, FF FF.
//  T4 CMD24 arg 7, FE, 512 bytes 0..FF,0..FF, 2 CRC -> 05, sd_wr=1, lba=7; host reads buffer
//     (1-cycle latency) matches; MISO 00 until ack fall, then FF.
//  T5 raise spi_ss mid-RD_DATA at byte 100 -> MISO=1, next CMD0 answered 0x01, no 2nd sd_rd.
//  T6 CMD2 -> 0x05 when idle_flag=1; reset_n pulse during sd_wr=1 -> sd_wr=0 immediately.

Source files
------------

// File: rtl/sd_card_spi_if.sv
// SPI wires toward the divmmc master plus the MiST user_io sector/buffer port.
// The card emulator is the slave side; the host controller and user_io are the master side.
interface sd_card_spi_if;
    logic        spi_ss;
    logic        spi_clk;
    logic        spi_do;
    logic        spi_di;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    modport master (
        output spi_ss, spi_clk, spi_do, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  spi_di, sd_lba, sd_rd, sd_wr, sd_buff_din
    );

    modport slave (
        input  spi_ss, spi_clk, spi_do, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output spi_di, sd_lba, sd_rd, sd_wr, sd_buff_din
    );
endinterface

// File: rtl/sd_card_spi.sv
// SDHC card emulator in SPI mode: decodes commands, answers R1/R3/R7, streams 512-byte sectors.
// MISO is one byte behind the byte being decoded; the SPI master is stalled with 0xFF/0x00 while the host is busy.
module sd_card_spi #(
    parameter int NCR     = 1,
    parameter int RD_WAIT = 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    sd_card_spi_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, CMD, NCR_WAIT, RESP, RD_REQ, RD_TOKEN, RD_DATA, RD_CRC,
        WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
    } state_t;

    state_t      state_q, nxt_q;
    logic        old_clk_q, old_ack_q;
    logic [2:0]  bitcnt_q;
    logic [6:0]  rx_sr_q;
    logic [7:0]  tx_q;
    logic        spi_di_q;
    logic [5:0]  cmd_q;
    logic [31:0] arg_q;
    logic [8:0]  cnt_q;
    logic [39:0] resp_q;
    logic [2:0]  resp_len_q;
    logic        idle_q, acmd_q, issued_q, hs_busy_q;
    logic        sd_rd_q, sd_wr_q;
    logic [31:0] sd_lba_q;
    logic [7:0]  sd_buff_din_q;
    logic [7:0]  spi_rd_q;
    logic [7:0]  mem [0:511];

    logic       spi_rise, spi_fall, byte_done, ack_rise, ack_fall, spi_we;
    logic [7:0] rx_byte, r1;

    assign spi_rise  = bus.spi_clk & ~old_clk_q;
    assign spi_fall  = ~bus.spi_clk & old_clk_q;
    assign byte_done = ~bus.spi_ss & spi_rise & (bitcnt_q == 3'd7);
    assign rx_byte   = {rx_sr_q, bus.spi_do};
    assign ack_rise  = bus.sd_ack & ~old_ack_q;
    assign ack_fall  = ~bus.sd_ack & old_ack_q;
    assign spi_we    = byte_done & (state_q == WR_DATA);
    assign r1        = {7'd0, idle_q};

    // Sector buffer: host and SPI ports are independent; the SPI read is prefetched every cycle
    // because cnt_q only moves on byte boundaries, many cycles apart.
    always_ff @(posedge clk_sys) begin
        if (bus.sd_buff_wr && bus.sd_ack) mem[bus.sd_buff_addr] <= bus.sd_buff_dout;
        if (spi_we) mem[cnt_q] <= rx_byte;
        spi_rd_q <= mem[cnt_q];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;          nxt_q <= IDLE;
            old_clk_q <= 1'b0;        old_ack_q <= 1'b0;
            bitcnt_q <= 3'd0;         rx_sr_q <= 7'd0;
            tx_q <= 8'hFF;            spi_di_q <= 1'b1;
            cmd_q <= 6'd0;            arg_q <= 32'd0;
            cnt_q <= 9'd0;            resp_q <= 40'd0;
            resp_len_q <= 3'd1;       idle_q <= 1'b1;
            acmd_q <= 1'b0;           issued_q <= 1'b0;
            hs_busy_q <= 1'b0;        sd_rd_q <= 1'b0;
            sd_wr_q <= 1'b0;          sd_lba_q <= 32'd0;
            sd_buff_din_q <= 8'd0;
        end else begin
            old_clk_q     <= bus.spi_clk;
            old_ack_q     <= bus.sd_ack;
            sd_buff_din_q <= mem[bus.sd_buff_addr];

            // Host handshake runs independently of chip select so an aborted transfer still completes.
            if (ack_rise) begin
                sd_rd_q <= 1'b0;
                sd_wr_q <= 1'b0;
            end
            if (ack_fall) hs_busy_q <= 1'b0;
            if (!bus.spi_ss && !issued_q && !hs_busy_q && (state_q == RD_REQ || state_q == WR_BUSY)) begin
                issued_q  <= 1'b1;
                hs_busy_q <= 1'b1;
                sd_lba_q  <= arg_q;
                if (state_q == RD_REQ) sd_rd_q <= 1'b1;
                else                   sd_wr_q <= 1'b1;
            end

            if (bus.spi_ss) begin
                bitcnt_q <= 3'd0;
                state_q  <= IDLE;
                spi_di_q <= 1'b1;
                tx_q     <= 8'hFF;
            end else begin
                if (spi_rise) begin
                    rx_sr_q  <= rx_byte[6:0];
                    bitcnt_q <= bitcnt_q + 3'd1;
                end
                if (spi_fall) spi_di_q <= tx_q[3'd7 - bitcnt_q];
                if (byte_done) begin
                    tx_q <= 8'hFF;
                    case (state_q)
                        IDLE: if (rx_byte[7:6] == 2'b01) begin
                            cmd_q   <= rx_byte[5:0];
                            cnt_q   <= 9'd0;
                            state_q <= CMD;
                        end
                        CMD: if (cnt_q[2:0] != 3'd4) begin
                            arg_q <= {arg_q[23:0], rx_byte};
                            cnt_q <= cnt_q + 9'd1;
                        end else begin
                            cnt_q      <= 9'd0;
                            state_q    <= NCR_WAIT;
                            nxt_q      <= IDLE;
                            acmd_q     <= 1'b0;
                            resp_len_q <= 3'd1;
                            resp_q     <= {r1 | 8'h04, 32'd0};
                            if (acmd_q) begin
                                if (cmd_q == 6'd41) begin
                                    idle_q <= 1'b0;
                                    resp_q <= 40'd0;
                                end
                            end else begin
                                case (cmd_q)
                                    6'd0:  begin idle_q <= 1'b1; resp_q <= {8'h01, 32'd0}; end
                                    6'd8:  begin resp_q <= {r1, 32'h0000_01AA}; resp_len_q <= 3'd5; end
                                    6'd16: resp_q <= {r1, 32'd0};
                                    6'd17: begin resp_q <= 40'd0; nxt_q <= RD_REQ; end
                                    6'd24: begin resp_q <= 40'd0; nxt_q <= WR_TOKEN; end
                                    6'd55: begin resp_q <= {r1, 32'd0}; acmd_q <= 1'b1; end
                                    6'd58: begin resp_q <= {r1, 32'hC0FF_8000}; resp_len_q <= 3'd5; end
                                    default: ;
                                endcase
                            end
                        end
                        NCR_WAIT: if (cnt_q == 9'(NCR - 1)) begin
                            tx_q    <= resp_q[39:32];
                            resp_q  <= {resp_q[31:0], 8'h00};
                            cnt_q   <= 9'd1;
                            state_q <= RESP;
                        end else begin
                            cnt_q <= cnt_q + 9'd1;
                        end
                        RESP: if (cnt_q == {6'd0, resp_len_q}) begin
                            state_q  <= nxt_q;
                            cnt_q    <= 9'd0;
                            issued_q <= 1'b0;
                        end else begin
                            tx_q   <= resp_q[39:32];
                            resp_q <= {resp_q[31:0], 8'h00};
                            cnt_q  <= cnt_q + 9'd1;
                        end
                        // cnt_q counts fillers already sent; the token only follows a finished handshake.
                        RD_REQ: if (issued_q && !hs_busy_q && (10'(cnt_q) + 10'd1 >= 10'(RD_WAIT))) begin
                            tx_q    <= 8'hFE;
                            cnt_q   <= 9'd0;
                            state_q <= RD_TOKEN;
                        end else if (cnt_q != 9'd511) begin
                            cnt_q <= cnt_q + 9'd1;
                        end
                        RD_TOKEN: begin
                            tx_q    <= spi_rd_q;
                            cnt_q   <= 9'd1;
                            state_q <= RD_DATA;
                        end
                        RD_DATA: begin
                            tx_q <= spi_rd_q;
                            if (cnt_q == 9'd511) begin
                                cnt_q   <= 9'd0;
                                state_q <= RD_CRC;
                            end else begin
                                cnt_q <= cnt_q + 9'd1;
                            end
                        end
                        RD_CRC: if (cnt_q == 9'd2) state_q <= IDLE;
                                else cnt_q <= cnt_q + 9'd1;
                        WR_TOKEN: if (rx_byte == 8'hFE) begin
                            cnt_q   <= 9'd0;
                            state_q <= WR_DATA;
                        end
                        WR_DATA: if (cnt_q == 9'd511) begin
                            cnt_q   <= 9'd0;
                            state_q <= WR_CRC;
                        end else begin
                            cnt_q <= cnt_q + 9'd1;
                        end
                        WR_CRC: if (cnt_q == 9'd1) begin
                            tx_q    <= 8'h05;
                            state_q <= WR_RESP;
                        end else begin
                            cnt_q <= cnt_q + 9'd1;
                        end
                        WR_RESP: begin
                            tx_q     <= 8'h00;
                            issued_q <= 1'b0;
                            state_q  <= WR_BUSY;
                        end
                        WR_BUSY: if (issued_q && !hs_busy_q) state_q <= IDLE;
                                 else tx_q <= 8'h00;
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.spi_di      = spi_di_q;
    assign bus.sd_lba      = sd_lba_q;
    assign bus.sd_rd       = sd_rd_q;
    assign bus.sd_wr       = sd_wr_q;
    assign bus.sd_buff_din = sd_buff_din_q;
endmodule

// File: tb/tb_sd_card_spi.sv
// Drives the SD emulator as an SPI master and a user_io host; responses and sector data are scoreboarded.
module tb_sd_card_spi;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_card_spi_if bus();
    sd_card_spi #(.NCR(1), .RD_WAIT(1)) dut (.clk_sys(clk), .reset_n(rst_n), .bus(bus.slave));

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] buf_q[$];
    logic rd_prev = 1'b0;
    int   rd_rises = 0;

    always @(posedge clk) begin
        rd_prev <= bus.sd_rd;
        if (bus.sd_rd && !rd_prev) rd_rises <= rd_rises + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
        for (int i = 7; i >= 0; i--) begin
            bus.spi_do = mosi[i];
            @(negedge clk);
            miso[i] = bus.spi_di;
            bus.spi_clk = 1'b1;
            repeat (2) @(negedge clk);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic xfer_exp(input string tag, input logic [7:0] mosi, input logic [7:0] exp);
        logic [7:0] got;
        exp_q.push_back(exp);
        xfer(mosi, got);
        check(tag, {24'd0, got}, {24'd0, exp_q.pop_front()});
    endtask

    task automatic send_cmd(input logic [5:0] cmd, input logic [31:0] arg);
        logic [47:0] fr;
        fr = {2'b01, cmd, arg, 8'h95};
        for (int i = 0; i < 6; i++) xfer_exp("cmd_miso", fr[47 - 8*i -: 8], 8'hFF);
        xfer_exp("ncr_fill", 8'hFF, 8'hFF);
    endtask

    task automatic resp(input string tag, input logic [39:0] r, input int n);
        for (int i = 0; i < n; i++) xfer_exp(tag, 8'hFF, r[39 - 8*i -: 8]);
    endtask

    task automatic wait_req(input bit wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr ? bus.sd_wr : bus.sd_rd) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic host_fill(input logic [7:0] key);
        bus.sd_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("rd_drop_on_ack", {31'd0, bus.sd_rd}, 32'd0);
        for (int i = 0; i < 512; i++) begin
            logic [8:0] a;
            a = 9'(i);
            bus.sd_buff_addr = a;
            bus.sd_buff_dout = a[7:0] ^ key;
            bus.sd_buff_wr   = 1'b1;
            buf_q.push_back(a[7:0] ^ key);
            @(negedge clk);
        end
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic read_sector(input int n);
        logic [7:0] got;
        int fill;
        fill = 0;
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            xfer(8'hFF, got);
            if (got == 8'hFE) break;
            fill++;
        end
        check("rd_token", {24'd0, got}, 32'hFE);
        check("rd_fill_min", {31'd0, (fill >= 1)}, 32'd1);
        for (int i = 0; i < n; i++) begin
            xfer(8'hFF, got);
            check("rd_data", {24'd0, got}, {24'd0, buf_q.pop_front()});
        end
    endtask

    task automatic write_sector(input logic [31:0] lba);
        logic [7:0] got;
        send_cmd(6'd24, lba);
        resp("cmd24_r1", 40'd0, 1);
        xfer_exp("wr_pre_token", 8'h00, 8'hFF);
        xfer_exp("wr_token_miso", 8'hFE, 8'hFF);
        for (int i = 0; i < 512; i++) begin
            logic [8:0] a;
            a = 9'(i);
            buf_q.push_back(a[7:0]);
            xfer(a[7:0], got);
        end
        xfer_exp("wr_crc_miso", 8'hAB, 8'hFF);
        xfer_exp("wr_crc_miso", 8'hCD, 8'hFF);
        xfer_exp("wr_data_resp", 8'hFF, 8'h05);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [7:0] got;
        bus.spi_ss = 1'b1; bus.spi_clk = 1'b0; bus.spi_do = 1'b1;
        bus.sd_ack = 1'b0; bus.sd_buff_addr = 9'd0; bus.sd_buff_dout = 8'd0; bus.sd_buff_wr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_spi_di", {31'd0, bus.spi_di}, 32'd1);
        check("rst_sd_rd", {31'd0, bus.sd_rd}, 32'd0);
        check("rst_sd_wr", {31'd0, bus.sd_wr}, 32'd0);
        check("rst_sd_lba", bus.sd_lba, 32'd0);
        check("rst_buff_din", {24'd0, bus.sd_buff_din}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1 / T2: init sequence
        bus.spi_ss = 1'b0;
        repeat (2) @(negedge clk);
        send_cmd(6'd0, 32'd0);           resp("cmd0", {8'h01, 32'd0}, 1);
        send_cmd(6'd8, 32'h1AA);         resp("cmd8", 40'h01_0000_01AA, 5);
        send_cmd(6'd41, 32'd0);          resp("cmd41_unarmed", {8'h05, 32'd0}, 1);
        send_cmd(6'd55, 32'd0);          resp("cmd55", {8'h01, 32'd0}, 1);
        send_cmd(6'd41, 32'h4000_0000);  resp("acmd41", 40'd0, 1);
        send_cmd(6'd58, 32'd0);          resp("cmd58", 40'h00_C0FF_8000, 5);
        send_cmd(6'd16, 32'd512);        resp("cmd16", 40'd0, 1);

        // T3: sector read
        send_cmd(6'd17, 32'h1234);       resp("cmd17_r1", 40'd0, 1);
        wait_req(1'b0, ok);
        check("t3_rd_req", {31'd0, ok}, 32'd1);
        check("t3_lba", bus.sd_lba, 32'h1234);
        host_fill(8'h5A);
        read_sector(512);
        resp("rd_crc", 40'hFFFF_0000_00, 2);

        // T4: sector write
        write_sector(32'd7);
        wait_req(1'b1, ok);
        check("t4_wr_req", {31'd0, ok}, 32'd1);
        check("t4_lba", bus.sd_lba, 32'd7);
        bus.sd_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("wr_drop_on_ack", {31'd0, bus.sd_wr}, 32'd0);
        for (int i = 0; i < 512; i++) begin
            bus.sd_buff_addr = 9'(i);
            @(negedge clk);
            check("wr_buf", {24'd0, bus.sd_buff_din}, {24'd0, buf_q.pop_front()});
        end
        xfer_exp("wr_busy", 8'hFF, 8'h00);
        bus.sd_ack = 1'b0;
        repeat (2) @(negedge clk);
        got = 8'h00;
        for (int i = 0; i < 4; i++) begin
            xfer(8'hFF, got);
            if (got != 8'h00) break;
        end
        check("wr_done", {24'd0, got}, 32'hFF);

        // T5: chip select raised mid-read
        send_cmd(6'd17, 32'h55);         resp("cmd17b_r1", 40'd0, 1);
        wait_req(1'b0, ok);
        check("t5_rd_req", {31'd0, ok}, 32'd1);
        host_fill(8'h3C);
        read_sector(100);
        buf_q.delete();
        bus.spi_ss = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_miso_idle", {31'd0, bus.spi_di}, 32'd1);
        repeat (100) @(negedge clk);
        bus.spi_ss = 1'b0;
        repeat (2) @(negedge clk);
        send_cmd(6'd0, 32'd0);           resp("t5_cmd0", {8'h01, 32'd0}, 1);
        repeat (20) @(negedge clk);
        check("t5_rd_count", rd_rises, 32'd2);

        // T6: illegal command, then reset while a write request is pending
        send_cmd(6'd2, 32'd0);           resp("cmd2_illegal", {8'h05, 32'd0}, 1);
        write_sector(32'd9);
        buf_q.delete();
        wait_req(1'b1, ok);
        check("t6_wr_req", {31'd0, ok}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_wr_async_clr", {31'd0, bus.sd_wr}, 32'd0);
        check("t6_lba_clr", bus.sd_lba, 32'd0);
        check("t6_miso_rst", {31'd0, bus.spi_di}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
